// File: rtl/noise_estimation_mc.sv
// Multi-lane block noise estimator: single-pass per-block variance (E[x^2]-mean^2)
// reduced over a frame to one noise figure per lane, as mean or minimum of block variances.
module noise_estimation_mc #(
  parameter int DATA_WIDTH      = 8,
  parameter int NUM_CHANNELS    = 3,
  parameter int SAMPLES_LOG2    = 3,
  parameter int MAX_BLOCKS_LOG2 = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]  data_in,
  input  logic                                valid_in,
  input  logic                                start_of_frame,
  input  logic [4:0]                          frame_blocks_log2,
  input  logic                                mode,
  output logic                                in_ready,
  output logic [NUM_CHANNELS*2*DATA_WIDTH-1:0] block_var,
  output logic                                block_valid,
  output logic [NUM_CHANNELS*2*DATA_WIDTH-1:0] noise_out,
  output logic                                noise_valid
);

  localparam int SW = DATA_WIDTH + SAMPLES_LOG2;
  localparam int QW = 2 * DATA_WIDTH + SAMPLES_LOG2;
  localparam int VW = 2 * DATA_WIDTH;
  localparam int AW = VW + MAX_BLOCKS_LOG2;
  localparam int BW = MAX_BLOCKS_LOG2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  localparam logic [SAMPLES_LOG2-1:0] SMP_ONE = 1;
  localparam logic [BW-1:0]           BLK_ONE = 1;
  localparam logic [BW:0]             MAX_ONE = 1;

  logic [1:0]              state_q, state_d;
  logic                    flush_cnt_q, flush_cnt_d;
  logic                    mode_q;
  logic [4:0]              log2_q;
  logic [SAMPLES_LOG2-1:0] smp_q;
  logic [BW-1:0]           blk_q;

  logic [SW-1:0] s_q     [NUM_CHANNELS];
  logic [QW-1:0] q_q     [NUM_CHANNELS];
  logic [SW-1:0] fin_s_q [NUM_CHANNELS];
  logic [QW-1:0] fin_q_q [NUM_CHANNELS];
  logic [VW-1:0] var_q   [NUM_CHANNELS];
  logic [AW-1:0] acc_q   [NUM_CHANNELS];
  logic [VW-1:0] min_q   [NUM_CHANNELS];
  logic [VW-1:0] noise_q [NUM_CHANNELS];

  logic fin_v_q, fin_last_q, var_red_q, var_last_q;
  logic block_valid_q, noise_valid_q;

  logic                    accept, start, beat, last_smp, last_blk;
  logic [SAMPLES_LOG2-1:0] smp_idx;
  logic [BW-1:0]           blk_idx;
  logic [4:0]              cur_log2;
  logic [BW:0]             blk_max;

  logic [SW-1:0] s_new     [NUM_CHANNELS];
  logic [QW-1:0] q_new     [NUM_CHANNELS];
  logic [VW-1:0] var_new   [NUM_CHANNELS];
  logic [AW-1:0] acc_new   [NUM_CHANNELS];
  logic [VW-1:0] min_new   [NUM_CHANNELS];
  logic [VW-1:0] noise_new [NUM_CHANNELS];

  assign in_ready = (state_q != S_FLUSH);
  assign accept   = valid_in & in_ready;
  assign start    = accept & start_of_frame;
  assign beat     = accept & (start | (state_q == S_ACCUM));

  // A frame start (including a restart) forces the beat to be sample 0 of block 0.
  assign smp_idx  = start ? '0 : smp_q;
  assign blk_idx  = start ? '0 : blk_q;
  assign cur_log2 = start ? frame_blocks_log2 : log2_q;
  assign blk_max  = (MAX_ONE << cur_log2) - MAX_ONE;
  assign last_smp = beat & (&smp_idx);
  assign last_blk = ({1'b0, blk_idx} == blk_max);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      S_IDLE, S_ACCUM: begin
        if (start) state_d = S_ACCUM;
        if (last_smp && last_blk) begin
          state_d     = S_FLUSH;
          flush_cnt_d = 1'b0;
        end
      end
      S_FLUSH: begin
        if (flush_cnt_q) state_d = S_IDLE;
        flush_cnt_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    logic [DATA_WIDTH-1:0] x, m;
    logic [VW-1:0]         sq, e, m2;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      x        = data_in[c*DATA_WIDTH +: DATA_WIDTH];
      sq       = VW'(x) * VW'(x);
      s_new[c] = (start ? '0 : s_q[c]) + SW'(x);
      q_new[c] = (start ? '0 : q_q[c]) + QW'(sq);

      m  = DATA_WIDTH'(fin_s_q[c] >> SAMPLES_LOG2);
      e  = VW'(fin_q_q[c] >> SAMPLES_LOG2);
      m2 = VW'(m) * VW'(m);
      var_new[c] = (e >= m2) ? (e - m2) : '0;

      acc_new[c]   = acc_q[c] + AW'(var_q[c]);
      min_new[c]   = (var_q[c] < min_q[c]) ? var_q[c] : min_q[c];
      noise_new[c] = mode_q ? min_new[c] : VW'(acc_new[c] >> log2_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the per-lane arrays are a handful of registers, not a RAM, so they reset with the rest.
      state_q       <= S_IDLE;
      flush_cnt_q   <= 1'b0;
      mode_q        <= 1'b0;
      log2_q        <= '0;
      smp_q         <= '0;
      blk_q         <= '0;
      fin_v_q       <= 1'b0;
      fin_last_q    <= 1'b0;
      var_red_q     <= 1'b0;
      var_last_q    <= 1'b0;
      block_valid_q <= 1'b0;
      noise_valid_q <= 1'b0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        s_q[c]     <= '0;
        q_q[c]     <= '0;
        fin_s_q[c] <= '0;
        fin_q_q[c] <= '0;
        var_q[c]   <= '0;
        acc_q[c]   <= '0;
        min_q[c]   <= '0;
        noise_q[c] <= '0;
      end
    end else begin
      // NOTE: non-blocking throughout so every stage sees the previous cycle's values.
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      if (start) begin
        mode_q <= mode;
        log2_q <= frame_blocks_log2;
      end
      if (beat) begin
        smp_q <= last_smp ? '0 : (smp_idx + SMP_ONE);
        blk_q <= last_smp ? (last_blk ? '0 : (blk_idx + BLK_ONE)) : blk_idx;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
          if (last_smp) begin
            fin_s_q[c] <= s_new[c];
            fin_q_q[c] <= q_new[c];
            s_q[c]     <= '0;
            q_q[c]     <= '0;
          end else begin
            s_q[c] <= s_new[c];
            q_q[c] <= q_new[c];
          end
        end
      end
      fin_v_q <= last_smp;
      if (last_smp) fin_last_q <= last_blk;

      block_valid_q <= fin_v_q;
      var_red_q     <= fin_v_q & ~start;
      var_last_q    <= fin_last_q;
      noise_valid_q <= var_red_q & var_last_q & ~start;

      // A restart wins over any in-flight block so stale variances never reach the new frame.
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (fin_v_q) var_q[c] <= var_new[c];
        if (start) begin
          acc_q[c] <= '0;
          min_q[c] <= '1;
        end else if (var_red_q) begin
          acc_q[c] <= acc_new[c];
          min_q[c] <= min_new[c];
          if (var_last_q) noise_q[c] <= noise_new[c];
        end
      end
    end
  end

  always_comb begin
    block_var = '0;
    noise_out = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      block_var[c*VW +: VW] = var_q[c];
      noise_out[c*VW +: VW] = noise_q[c];
    end
  end

  assign block_valid = block_valid_q;
  assign noise_valid = noise_valid_q;

endmodule

// File: tb/tb_noise_estimation_mc.sv
// Directed bench for noise_estimation_mc with two lanes; expected variances and
// noise figures are hand-computed from alternating 0/2d patterns (variance d^2).
module tb_noise_estimation_mc;

  localparam int DW = 8;
  localparam int NC = 2;
  localparam int VW = 2 * DW;

  logic              clk = 1'b0;
  logic              rst;
  logic [NC*DW-1:0]  data_in;
  logic              valid_in;
  logic              start_of_frame;
  logic [4:0]        frame_blocks_log2;
  logic              mode;
  logic              in_ready;
  logic [NC*VW-1:0]  block_var;
  logic              block_valid;
  logic [NC*VW-1:0]  noise_out;
  logic              noise_valid;

  noise_estimation_mc #(
    .DATA_WIDTH(DW), .NUM_CHANNELS(NC), .SAMPLES_LOG2(3), .MAX_BLOCKS_LOG2(16)
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
    .start_of_frame(start_of_frame), .frame_blocks_log2(frame_blocks_log2),
    .mode(mode), .in_ready(in_ready), .block_var(block_var),
    .block_valid(block_valid), .noise_out(noise_out), .noise_valid(noise_valid)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_cyc = 0;
  int nv_cnt = 0;
  int nv_cyc = 0;
  int ir_lo = 0;
  logic [NC*VW-1:0] noise_seen = '0;
  logic [NC*VW-1:0] bv_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (block_valid) bv_q.push_back(block_var);
    if (noise_valid) begin
      nv_cnt++;
      nv_cyc = cyc;
      noise_seen = noise_out;
    end
    if (!in_ready) ir_lo++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input logic [7:0] l0, input logic [7:0] l1, input logic sof,
                           input int gap);
    int w;
    for (int g = 0; g < 3 && $urandom_range(0, 99) < gap; g++) begin
      @(negedge clk);
      valid_in = 1'b0;
      start_of_frame = 1'b0;
    end
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 20) begin
      valid_in = 1'b0;
      @(negedge clk);
      w++;
    end
    if (!in_ready) check("ready_timeout", 64'(in_ready), 64'd1);
    data_in = {l1, l0};
    valid_in = 1'b1;
    start_of_frame = sof;
    last_cyc = cyc;
  endtask

  task automatic send_block(input logic [7:0] a0, input logic [7:0] a1,
                            input logic [7:0] b0, input logic [7:0] b1,
                            input logic sof, input int gap);
    for (int i = 0; i < 8; i++)
      send_beat(i[0] ? a1 : a0, i[0] ? b1 : b0, sof && (i == 0), gap);
  endtask

  task automatic go_idle();
    @(negedge clk);
    valid_in = 1'b0;
    start_of_frame = 1'b0;
  endtask

  // Let the pipeline drain, then check strobe count, latency, value and ready-low cycles.
  task automatic finish_frame(input string tag, input logic [NC*VW-1:0] exp,
                              input int nv0, input int ir0);
    go_idle();
    repeat (6) @(negedge clk);
    check({tag, "_nv_count"}, 64'(nv_cnt - nv0), 64'd1);
    check({tag, "_latency"}, 64'(nv_cyc - last_cyc), 64'd3);
    check({tag, "_noise"}, 64'(noise_seen), 64'(exp));
    check({tag, "_noise_hold"}, 64'(noise_out), 64'(exp));
    check({tag, "_ready_low"}, 64'(ir_lo - ir0), 64'd2);
  endtask

  task automatic frame4(input string tag, input logic md, input int gap,
                        input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] d2, input logic [7:0] d3,
                        input logic [NC*VW-1:0] exp);
    logic [7:0] d[4];
    int nv0, ir0, qs;
    logic [VW-1:0] v0, v1;
    d = '{d0, d1, d2, d3};
    nv0 = nv_cnt;
    ir0 = ir_lo;
    qs  = bv_q.size();
    frame_blocks_log2 = 5'd2;
    mode = md;
    for (int b = 0; b < 4; b++)
      send_block(8'd0, 8'(2 * d[b]), 8'd0, 8'(2 * d[3-b]), b == 0, gap);
    finish_frame(tag, exp, nv0, ir0);
    check({tag, "_nblocks"}, 64'(bv_q.size() - qs), 64'd4);
    for (int b = 0; b < 4; b++) begin
      v0 = VW'(d[b]) * VW'(d[b]);
      v1 = VW'(d[3-b]) * VW'(d[3-b]);
      check($sformatf("%s_bvar%0d", tag, b), 64'(bv_q[qs+b]), 64'({v1, v0}));
    end
  endtask

  initial begin
    int nv0, ir0, qs;
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int nv0, ir0, qs;
    rst = 1'b1;
    data_in = '0;
    valid_in = 1'b0;
    start_of_frame = 1'b0;
    frame_blocks_log2 = '0;
    mode = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_block_var", 64'(block_var), 64'd0);
    check("rst_noise_out", 64'(noise_out), 64'd0);
    check("rst_strobes", 64'({block_valid, noise_valid}), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;

    // Constant frame: every block variance and the mean are 0.
    nv0 = nv_cnt; ir0 = ir_lo; qs = bv_q.size();
    frame_blocks_log2 = 5'd2;
    mode = 1'b0;
    for (int b = 0; b < 4; b++) send_block(8'd10, 8'd10, 8'd10, 8'd10, b == 0, 0);
    finish_frame("const", '0, nv0, ir0);
    check("const_nblocks", 64'(bv_q.size() - qs), 64'd4);
    for (int b = 0; b < 4; b++) check($sformatf("const_bvar%0d", b), 64'(bv_q[qs+b]), 64'd0);

    // Single-block frames: lane0 0/2 -> 1, lane1 0/255 -> 32512-127^2 = 16383.
    for (int md = 0; md < 2; md++) begin
      nv0 = nv_cnt; ir0 = ir_lo;
      frame_blocks_log2 = 5'd0;
      mode = md[0];
      send_block(8'd0, 8'd2, 8'd0, 8'd255, 1'b1, 0);
      finish_frame($sformatf("one_blk_m%0d", md), {16'd16383, 16'd1}, nv0, ir0);
      check($sformatf("one_blk_bvar_m%0d", md), 64'(block_var), 64'({16'd16383, 16'd1}));
    end

    // Variances 4,1,9,16 (lane1 reversed): mean 30>>2 = 7, minimum 1.
    frame4("mean", 1'b0, 0, 8'd2, 8'd1, 8'd3, 8'd4, {16'd7, 16'd7});
    frame4("min", 1'b1, 0, 8'd2, 8'd1, 8'd3, 8'd4, {16'd1, 16'd1});
    frame4("min_next", 1'b1, 0, 8'd5, 8'd5, 8'd5, 8'd5, {16'd25, 16'd25});

    // Restart after 5 beats of block 1; the aborted frame must produce no noise strobe.
    nv0 = nv_cnt; qs = bv_q.size();
    frame_blocks_log2 = 5'd2;
    mode = 1'b0;
    send_block(8'd0, 8'd4, 8'd0, 8'd4, 1'b1, 0);
    for (int i = 0; i < 5; i++) send_beat(8'd100, 8'd200, 1'b0, 0);
    frame4("restart", 1'b0, 0, 8'd2, 8'd1, 8'd3, 8'd4, {16'd7, 16'd7});
    check("restart_nv_total", 64'(nv_cnt - nv0), 64'd1);
    check("restart_aborted_bvar", 64'(bv_q[qs]), 64'({16'd4, 16'd4}));

    // Idle gaps on valid_in must not change any result.
    frame4("gaps", 1'b0, 30, 8'd2, 8'd1, 8'd3, 8'd4, {16'd7, 16'd7});
    frame4("gaps_min", 1'b1, 30, 8'd2, 8'd1, 8'd3, 8'd4, {16'd1, 16'd1});

    // Reset in the middle of accumulation.
    nv0 = nv_cnt; qs = bv_q.size();
    frame_blocks_log2 = 5'd2;
    mode = 1'b0;
    send_block(8'd0, 8'd4, 8'd0, 8'd4, 1'b1, 0);
    for (int i = 0; i < 3; i++) send_beat(8'd7, 8'd9, 1'b0, 0);
    @(negedge clk);
    valid_in = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_accum_block_var", 64'(block_var), 64'd0);
    check("rst_accum_noise_out", 64'(noise_out), 64'd0);
    check("rst_accum_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    qs = bv_q.size();
    for (int i = 0; i < 8; i++) send_beat(8'd0, 8'd8, 1'b0, 0);
    go_idle();
    repeat (6) @(negedge clk);
    check("rst_accum_no_bvalid", 64'(bv_q.size() - qs), 64'd0);
    check("rst_accum_no_nvalid", 64'(nv_cnt - nv0), 64'd0);

    // Reset during FLUSH: the in-flight block and frame strobes must be lost.
    nv0 = nv_cnt; qs = bv_q.size();
    frame_blocks_log2 = 5'd0;
    send_block(8'd0, 8'd2, 8'd0, 8'd255, 1'b1, 0);
    @(negedge clk);
    valid_in = 1'b0;
    start_of_frame = 1'b0;
    check("flush_entered", 64'(in_ready), 64'd0);
    rst = 1'b1;
    #1;
    check("rst_flush_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_flush_no_bvalid", 64'(bv_q.size() - qs), 64'd0);
    check("rst_flush_no_nvalid", 64'(nv_cnt - nv0), 64'd0);
    check("rst_flush_block_var", 64'(block_var), 64'd0);

    frame4("recover", 1'b0, 0, 8'd2, 8'd1, 8'd3, 8'd4, {16'd7, 16'd7});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
